trace_checker: RTL and testbench

Streaming checker for CPU write-back trace text, one ASCII character per accepted cycle. It recognises register-write records (`^time@pc: $grf <= data#`) and memory-write records (`^time@pc: *addr <= data#`). For each well-formed record it reports the record type and a semantic error vector, and it keeps saturating statistics counters. It is the parametrised successor of the single-format trace checker: address windows, register count, data width and counter width are configurable, input is qualified by a valid strobe, and it adds the counters.

---
 rtl/trace_checker.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_trace_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/trace_checker.sv
// trace_checker
//
// Streaming checker for CPU write-back trace text. One ASCII character is
// consumed per accepted cycle. Two record shapes are recognised:
//   register write : ^time@pc: $grf <= data#
//   memory write   : ^time@pc: *addr <= data#
// Spaces are allowed after ':', around '<=' and before '#'. A well-formed
// record is reported for one accepted character on format_type/error_code
// and is tallied in saturating statistics counters.
//
// Handshake: char is consumed on every rising edge where char_valid is 1.
// There is no ready/back-pressure; cycles with char_valid = 0 are invisible
// (no state change, outputs held). clr is independent of char_valid.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   char         ASCII character
//   char_valid   qualifies char
//   freq         power of two >= 2, sampled on the edge that accepts '#'
//   clr          synchronous clear of all counters (wins over increments)
//   format_type  0 none/illegal, 1 register record, 2 memory record
//   error_code   bit0 time, bit1 pc, bit2 addr, bit3 grf
//   reg_cnt      well-formed register records (saturating)
//   mem_cnt      well-formed memory records (saturating)
//   err_cnt      well-formed records with nonzero error_code (saturating)
//   state_dbg    current FSM state encoding (IDLE = 0)

module trace_checker #(
   parameter int unsigned DATA_DIGITS = 8,
   parameter logic [31:0] PC_LO       = 32'h0000_3000,
   parameter logic [31:0] PC_HI       = 32'h0000_4fff,
   parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
   parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
   parameter int unsigned GRF_NUM     = 32,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       char,
   input  logic             char_valid,
   input  logic [15:0]      freq,
   input  logic             clr,
   output logic [1:0]       format_type,
   output logic [3:0]       error_code,
   output logic [CNT_W-1:0] reg_cnt,
   output logic [CNT_W-1:0] mem_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [3:0]       state_dbg
);

   localparam int DW = $clog2(DATA_DIGITS + 1);

   localparam logic [7:0] CH_CARET = 8'h5E; // '^'
   localparam logic [7:0] CH_AT    = 8'h40; // '@'
   localparam logic [7:0] CH_COLON = 8'h3A; // ':'
   localparam logic [7:0] CH_SPACE = 8'h20; // ' '
   localparam logic [7:0] CH_DOLLAR= 8'h24; // '$'
   localparam logic [7:0] CH_STAR  = 8'h2A; // '*'
   localparam logic [7:0] CH_LT    = 8'h3C; // '<'
   localparam logic [7:0] CH_EQ    = 8'h3D; // '='
   localparam logic [7:0] CH_HASH  = 8'h23; // '#'

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_TIME  = 4'd1,
      S_PC    = 4'd2,
      S_COLON = 4'd3,
      S_SP1   = 4'd4,
      S_GRF   = 4'd5,
      S_ADDR  = 4'd6,
      S_SP2   = 4'd7,
      S_LT    = 4'd8,
      S_EQ    = 4'd9,
      S_SP3   = 4'd10,
      S_DATA  = 4'd11,
      S_SP4   = 4'd12
   } state_t;

   state_t         state;
   logic [13:0]    time_v;
   logic [31:0]    pc_v;
   logic [13:0]    grf_v;
   logic [31:0]    addr_v;
   logic [3:0]     dig_cnt;   // digit count of the field currently being parsed
   logic [DW-1:0]  data_cnt;
   logic           is_mem;

   logic           is_dec;
   logic           is_hex;
   logic [3:0]     hex_val;
   logic           data_full;
   logic           report;
   logic [15:0]    time_mask;
   logic [3:0]     err_vec;

   assign state_dbg = state;

   // Character classification. For 'a'-'f' and 'A'-'F' the low nibble is
   // 1..6, so adding 9 yields 10..15.
   always_comb begin
      is_dec  = (char >= 8'h30) && (char <= 8'h39);
      is_hex  = is_dec
                || ((char >= 8'h61) && (char <= 8'h66))
                || ((char >= 8'h41) && (char <= 8'h46));
      hex_val = is_dec ? char[3:0] : (char[3:0] + 4'd9);
   end

   assign data_full = (data_cnt == DW'(DATA_DIGITS));

   // A record is reported when '#' is accepted after a complete data field.
   assign report = char_valid && (char == CH_HASH)
                   && (((state == S_DATA) && data_full) || (state == S_SP4));

   // Semantic error vector, meaningful only when report is high.
   always_comb begin
      time_mask  = (freq >> 1) - 16'd1;
      err_vec    = 4'd0;
      err_vec[0] = |({2'b00, time_v} & time_mask);
      err_vec[1] = (pc_v < PC_LO) || (pc_v > PC_HI) || (|pc_v[1:0]);
      err_vec[2] = is_mem && ((addr_v < ADDR_LO) || (addr_v > ADDR_HI)
                              || (|addr_v[1:0]));
      err_vec[3] = !is_mem && ({18'd0, grf_v} >= GRF_NUM);
   end

   // Parser FSM, field accumulators and registered report outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         time_v      <= 14'd0;
         pc_v        <= 32'd0;
         grf_v       <= 14'd0;
         addr_v      <= 32'd0;
         dig_cnt     <= 4'd0;
         data_cnt    <= '0;
         is_mem      <= 1'b0;
         format_type <= 2'd0;
         error_code  <= 4'd0;
      end else if (char_valid) begin
         // Any accepted character retires the previous report.
         format_type <= 2'd0;
         error_code  <= 4'd0;
         if (char == CH_CARET) begin
            // Restart: a caret always opens a fresh record.
            state    <= S_TIME;
            time_v   <= 14'd0;
            pc_v     <= 32'd0;
            grf_v    <= 14'd0;
            addr_v   <= 32'd0;
            dig_cnt  <= 4'd0;
            data_cnt <= '0;
            is_mem   <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  state <= S_IDLE;
               end
               S_TIME: begin
                  if (is_dec && (dig_cnt < 4'd4)) begin
                     time_v  <= (time_v * 14'd10) + {10'd0, char[3:0]};
                     dig_cnt <= dig_cnt + 4'd1;
                  end else if ((char == CH_AT) && (dig_cnt != 4'd0)) begin
                     state   <= S_PC;
                     dig_cnt <= 4'd0;
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_PC: begin
                  // After the 8th digit only ':' may follow.
                  if (is_hex) begin
                     pc_v    <= {pc_v[27:0], hex_val};
                     dig_cnt <= dig_cnt + 4'd1;
                     if (dig_cnt == 4'd7) state <= S_COLON;
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_COLON: begin
                  state <= (char == CH_COLON) ? S_SP1 : S_IDLE;
               end
               S_SP1: begin
                  if (char == CH_SPACE) begin
                     state <= S_SP1;
                  end else if (char == CH_DOLLAR) begin
                     state   <= S_GRF;
                     dig_cnt <= 4'd0;
                     is_mem  <= 1'b0;
                  end else if (char == CH_STAR) begin
                     state   <= S_ADDR;
                     dig_cnt <= 4'd0;
                     is_mem  <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_GRF: begin
                  if (is_dec && (dig_cnt < 4'd4)) begin
                     grf_v   <= (grf_v * 14'd10) + {10'd0, char[3:0]};
                     dig_cnt <= dig_cnt + 4'd1;
                  end else if ((char == CH_SPACE) && (dig_cnt != 4'd0)) begin
                     state <= S_SP2;
                  end else if ((char == CH_LT) && (dig_cnt != 4'd0)) begin
                     state <= S_LT;
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_ADDR: begin
                  // After the 8th digit the field is closed; a further hex
                  // digit is then rejected by S_SP2.
                  if (is_hex) begin
                     addr_v  <= {addr_v[27:0], hex_val};
                     dig_cnt <= dig_cnt + 4'd1;
                     if (dig_cnt == 4'd7) state <= S_SP2;
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_SP2: begin
                  if (char == CH_SPACE)   state <= S_SP2;
                  else if (char == CH_LT) state <= S_LT;
                  else                    state <= S_IDLE;
               end
               S_LT: begin
                  state <= (char == CH_EQ) ? S_EQ : S_IDLE;
               end
               S_EQ, S_SP3: begin
                  if (char == CH_SPACE) begin
                     state <= S_SP3;
                  end else if (is_hex) begin
                     state    <= S_DATA;
                     data_cnt <= DW'(1);
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_DATA: begin
                  if (is_hex && !data_full) begin
                     data_cnt <= data_cnt + DW'(1);
                  end else if ((char == CH_SPACE) && data_full) begin
                     state <= S_SP4;
                  end else if (report) begin
                     state       <= S_IDLE;
                     format_type <= is_mem ? 2'd2 : 2'd1;
                     error_code  <= err_vec;
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_SP4: begin
                  if (char == CH_SPACE) begin
                     state <= S_SP4;
                  end else if (report) begin
                     state       <= S_IDLE;
                     format_type <= is_mem ? 2'd2 : 2'd1;
                     error_code  <= err_vec;
                  end else begin
                     state <= S_IDLE;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Saturating statistics counters; clr overrides any increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_cnt <= '0;
         mem_cnt <= '0;
         err_cnt <= '0;
      end else if (clr) begin
         reg_cnt <= '0;
         mem_cnt <= '0;
         err_cnt <= '0;
      end else if (report) begin
         if (is_mem) begin
            if (mem_cnt != {CNT_W{1'b1}}) mem_cnt <= mem_cnt + CNT_W'(1);
         end else begin
            if (reg_cnt != {CNT_W{1'b1}}) reg_cnt <= reg_cnt + CNT_W'(1);
         end
         if ((err_vec != 4'd0) && (err_cnt != {CNT_W{1'b1}}))
            err_cnt <= err_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker. Counters are built 2 bits wide so that
// saturation at 3 can be reached with a handful of records.

module tb_trace_checker;

   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    ch = 8'h00;
   logic          ch_valid = 1'b0;
   logic [15:0]   freq = 16'd2;
   logic          clr = 1'b0;
   logic [1:0]    format_type;
   logic [3:0]    error_code;
   logic [CW-1:0] reg_cnt;
   logic [CW-1:0] mem_cnt;
   logic [CW-1:0] err_cnt;
   logic [3:0]    state_dbg;

   int n_cmp = 0;
   int n_mis = 0;

   trace_checker #(.CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .char       (ch),
      .char_valid (ch_valid),
      .freq       (freq),
      .clr        (clr),
      .format_type(format_type),
      .error_code (error_code),
      .reg_cnt    (reg_cnt),
      .mem_cnt    (mem_cnt),
      .err_cnt    (err_cnt),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One accepted character; returns 1 time unit after the accepting edge.
   task automatic send_char(input byte c, input logic c_clr = 1'b0);
      @(negedge clk);
      ch       = c;
      ch_valid = 1'b1;
      clr      = c_clr;
      @(posedge clk);
      #1;
      ch_valid = 1'b0;
      clr      = 1'b0;
   endtask

   // Invalid cycles carrying a caret: must be ignored and hold the report.
   task automatic idle_check(input int n, input logic [1:0] exp_ft);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         ch       = 8'h5E;
         ch_valid = 1'b0;
         @(posedge clk);
         #1;
         check("hold_ft", {30'd0, format_type}, {30'd0, exp_ft});
      end
   endtask

   task automatic send_str(input string s, input int gap_every = 0, input int gap_len = 0);
      for (int i = 0; i < s.len(); i++) begin
         send_char(s[i]);
         if ((gap_every != 0) && (((i + 1) % gap_every) == 0) && (i != s.len() - 1))
            idle_check(gap_len, 2'd0);
      end
   endtask

   task automatic check_report(input string tag, input logic [1:0] ft, input logic [3:0] ec);
      check({tag, "_ft"}, {30'd0, format_type}, {30'd0, ft});
      check({tag, "_ec"}, {28'd0, error_code}, {28'd0, ec});
   endtask

   task automatic check_cnts(input string tag, input int r, input int m, input int e);
      check({tag, "_reg"}, {30'd0, reg_cnt}, r);
      check({tag, "_mem"}, {30'd0, mem_cnt}, m);
      check({tag, "_err"}, {30'd0, err_cnt}, e);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_report("rst", 2'd0, 4'd0);
      check_cnts("rst", 0, 0, 0);
      check("rst_state", {28'd0, state_dbg}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Register record, then the next '^' clears the report
      freq = 16'd2;
      send_str("^242@000030f4: $31 <= 12345678#");
      check_report("reg1", 2'd1, 4'd0);
      check_cnts("reg1", 1, 0, 0);
      send_char("^");
      check_report("reg1_clear", 2'd0, 4'd0);

      // Memory record, mixed-case data
      send_str("^338@00003130: *00000088 <= ffFfb528#");
      check_report("mem1", 2'd2, 4'd0);
      check_cnts("mem1", 1, 1, 0);
      // Seven data digits: malformed
      send_str("^338@00003130: *00000088 <= ffFfb52#");
      check_report("data7", 2'd0, 4'd0);
      check_cnts("data7", 1, 1, 0);
      // Nine data digits: overflow
      send_str("^338@00003130: *00000088 <= ffFfb5280#");
      check_report("data9", 2'd0, 4'd0);
      check_cnts("data9", 1, 1, 0);

      // freq=8: time, pc and grf errors
      freq = 16'd8;
      send_str("^243@00003002: $32 <= 00000000#");
      check_report("errs", 2'd1, 4'b1011);
      check_cnts("errs", 2, 1, 1);
      send_char("x");
      check_report("any_char_clear", 2'd0, 4'd0);

      // No spaces; address above window
      freq = 16'd2;
      send_str("^1@00003000:*00003000<=00000000#");
      check_report("nosp", 2'd2, 4'b0100);
      check_cnts("nosp", 2, 2, 2);
      // Empty grf field
      send_str("^1@00003000:$   <=   00000000#");
      check_report("grf_empty", 2'd0, 4'd0);
      check_cnts("grf_empty", 2, 2, 2);
      // Fifth time digit
      send_str("^12345@00003000:$0<=00000000#");
      check_report("time5", 2'd0, 4'd0);

      // Restart plus valid gaps carrying junk
      send_str("^12@^0@00003000:   $0   <=   00000000   #", 5, 3);
      check_report("restart", 2'd1, 4'd0);
      check_cnts("restart", 3, 2, 2);
      idle_check(3, 2'd1);
      check("hold_ec", {28'd0, error_code}, 32'd0);

      // Saturation of 2-bit counters
      send_str("^242@000030f4: $31 <= 12345678#");
      check_report("sat_reg", 2'd1, 4'd0);
      check_cnts("sat_reg", 3, 2, 2);
      freq = 16'd8;
      send_str("^243@00003002: $32 <= 00000000#");
      send_str("^243@00003002: $32 <= 00000000#");
      check_report("sat_err", 2'd1, 4'b1011);
      check_cnts("sat_err", 3, 2, 3);
      freq = 16'd2;

      // PC upper edge legal, lower side illegal
      send_str("^0@00004ffc:$1<=00000000#");
      check_report("pc_hi_edge", 2'd1, 4'd0);
      send_str("^0@00002ffc:*00002ffc<=00000000#");
      check_report("pc_lo_out", 2'd2, 4'b0010);

      // Reset in the middle of a record
      send_str("^1@00003000:$0<=");
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_state", {28'd0, state_dbg}, 32'd0);
      check_cnts("midrst", 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      send_str("00000000#");
      check_report("after_rst", 2'd0, 4'd0);
      check_cnts("after_rst", 0, 0, 0);

      // clr coinciding with a reporting '#'
      send_str("^5@00003ffc:$7<=0000abcd#");
      check_report("pre_clr", 2'd1, 4'd0);
      check_cnts("pre_clr", 1, 0, 0);
      send_str("^5@00005000:*00002ffc<=0000abcd");
      send_char("#", 1'b1);
      check_report("clr_hash", 2'd2, 4'b0010);
      check_cnts("clr_hash", 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
